// File: rtl/tree_pkg.sv
// Shared widths, branch encoding and state encoding for the tree node datapath.
package tree_pkg;

  localparam int unsigned DefFeatures        = 3;
  localparam int unsigned DefCoeffBitDepth   = 4;
  localparam int unsigned DefBiasBitDepth    = 10;
  localparam int unsigned DefFeatureBitDepth = 10;
  localparam int unsigned DefAccBitDepth     = 18;
  localparam int unsigned DefProdBitDepth    = DefCoeffBitDepth + DefFeatureBitDepth;
  localparam int unsigned DefLevelBitDepth   = $clog2(DefFeatures);

  // Negative accumulator branches left.
  localparam logic DirLeft  = 1'b0;
  localparam logic DirRight = 1'b1;

  typedef enum logic {
    StIdle   = 1'b0,
    StLoaded = 1'b1
  } dp_state_e;

  // Width of a counter that must reach n inclusive.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tree_mac.sv
// Signed term select (unit / coeff product / zero) and the node accumulator.
module tree_mac
  import tree_pkg::*;
#(
  parameter int unsigned COEFF_BIT_DEPTH   = DefCoeffBitDepth,
  parameter int unsigned BIAS_BIT_DEPTH    = DefBiasBitDepth,
  parameter int unsigned FEATURE_BIT_DEPTH = DefFeatureBitDepth,
  parameter int unsigned ACC_BIT_DEPTH     = DefAccBitDepth
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         add,
  input  logic                         load_bias,
  input  logic                         mult,
  input  logic                         is_one,
  input  logic                         zero_term,
  input  logic [COEFF_BIT_DEPTH-1:0]   coeff,
  input  logic [BIAS_BIT_DEPTH-1:0]    bias,
  input  logic [FEATURE_BIT_DEPTH-1:0] feature,
  output logic                         acc_neg
);

  localparam int unsigned ProdW = COEFF_BIT_DEPTH + FEATURE_BIT_DEPTH;
  // Wide enough that every operand sign-extends into it; the result wraps to ACC_BIT_DEPTH.
  localparam int unsigned SumW  = ACC_BIT_DEPTH + ProdW + BIAS_BIT_DEPTH;

  logic [ProdW-1:0]         coeff_ext, feature_ext, term;
  logic [SumW-1:0]          base, sum;
  logic [ACC_BIT_DEPTH-1:0] acc_q, acc_d;
  logic                     unused_sum_hi;

  always_comb begin
    coeff_ext   = {{FEATURE_BIT_DEPTH{coeff[COEFF_BIT_DEPTH-1]}}, coeff};
    feature_ext = {{COEFF_BIT_DEPTH{feature[FEATURE_BIT_DEPTH-1]}}, feature};
    term        = '0;
    if (!zero_term) begin
      if (is_one) begin
        term = feature_ext;
      end else if (mult) begin
        term = coeff_ext * feature_ext;
      end
    end
    if (load_bias) begin
      base = {{(SumW - BIAS_BIT_DEPTH){bias[BIAS_BIT_DEPTH-1]}}, bias};
    end else begin
      base = {{(SumW - ACC_BIT_DEPTH){acc_q[ACC_BIT_DEPTH-1]}}, acc_q};
    end
    sum   = base + {{(SumW - ProdW){term[ProdW-1]}}, term};
    acc_d = add ? sum[ACC_BIT_DEPTH-1:0] : acc_q;
  end

  assign unused_sum_hi = ^sum[SumW-1:ACC_BIT_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_neg = acc_q[ACC_BIT_DEPTH-1];

endmodule

// File: rtl/tree_node_datapath.sv
// Decision-tree node evaluator: sample buffer, feature index, hyperplane MAC and leaf capture.
module tree_node_datapath
  import tree_pkg::*;
#(
  parameter int unsigned FEATURES          = DefFeatures,
  parameter int unsigned COEFF_BIT_DEPTH   = DefCoeffBitDepth,
  parameter int unsigned BIAS_BIT_DEPTH    = DefBiasBitDepth,
  parameter int unsigned FEATURE_BIT_DEPTH = DefFeatureBitDepth,
  parameter int unsigned ACC_BIT_DEPTH     = DefAccBitDepth,
  localparam int unsigned LevelW           = $clog2(FEATURES)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [FEATURES*FEATURE_BIT_DEPTH-1:0] features,
  input  logic                                  load_bias,
  input  logic                                  add,
  input  logic                                  mult,
  input  logic                                  is_one,
  input  logic [COEFF_BIT_DEPTH-1:0]            coeff,
  input  logic [BIAS_BIT_DEPTH-1:0]             bias,
  input  logic                                  out_valid,
  input  logic [LevelW-1:0]                     level,
  input  logic [LevelW-1:0]                     path,
  output logic                                  child_direction,
  output logic                                  next,
  output logic                                  class_valid,
  output logic [LevelW-1:0]                     class_level,
  output logic [LevelW-1:0]                     class_path,
  output logic                                  sample_missing,
  output logic                                  cmd_overrun
);

  localparam int unsigned IdxW = cnt_width(FEATURES);

  dp_state_e                             state_q, state_d;
  logic [FEATURES*FEATURE_BIT_DEPTH-1:0] sample_q;
  logic [IdxW-1:0]                       fidx_q, fidx_d, term_idx;
  logic [FEATURE_BIT_DEPTH-1:0]          feature_sel;
  logic                                  loaded, overrun, mac_add, capture;
  logic                                  next_q, next_d;
  logic                                  class_valid_q;
  logic [LevelW-1:0]                     class_level_q, class_path_q;
  logic                                  sample_missing_q, sample_missing_d;
  logic                                  cmd_overrun_q, cmd_overrun_d;
  logic                                  acc_neg;

  assign loaded  = (state_q == StLoaded);
  assign capture = out_valid && loaded;

  // Release takes priority: in_valid is only looked at while idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (in_valid)  state_d = StLoaded;
      StLoaded: if (out_valid) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    term_idx = load_bias ? '0 : fidx_q;
    overrun  = add && !load_bias && (fidx_q == IdxW'(FEATURES));
    mac_add  = add && !overrun;

    feature_sel = '0;
    for (int unsigned k = 0; k < FEATURES; k++) begin
      if (term_idx == IdxW'(k)) begin
        feature_sel = sample_q[k*FEATURE_BIT_DEPTH +: FEATURE_BIT_DEPTH];
      end
    end

    fidx_d = fidx_q;
    if (add) begin
      if (load_bias) begin
        fidx_d = IdxW'(1);
      end else if (!overrun) begin
        fidx_d = fidx_q + 1'b1;
      end
    end

    next_d           = mac_add && (term_idx == IdxW'(FEATURES - 1));
    sample_missing_d = sample_missing_q || (add && !loaded);
    cmd_overrun_d    = cmd_overrun_q || overrun;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      sample_q         <= '0;
      fidx_q           <= '0;
      next_q           <= 1'b0;
      class_valid_q    <= 1'b0;
      class_level_q    <= '0;
      class_path_q     <= '0;
      sample_missing_q <= 1'b0;
      cmd_overrun_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      fidx_q           <= fidx_d;
      next_q           <= next_d;
      class_valid_q    <= capture;
      sample_missing_q <= sample_missing_d;
      cmd_overrun_q    <= cmd_overrun_d;
      if (in_valid && !loaded) begin
        sample_q <= features;
      end
      if (capture) begin
        class_level_q <= level;
        class_path_q  <= path;
      end
    end
  end

  tree_mac #(
    .COEFF_BIT_DEPTH   (COEFF_BIT_DEPTH),
    .BIAS_BIT_DEPTH    (BIAS_BIT_DEPTH),
    .FEATURE_BIT_DEPTH (FEATURE_BIT_DEPTH),
    .ACC_BIT_DEPTH     (ACC_BIT_DEPTH)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .add       (mac_add),
    .load_bias (load_bias),
    .mult      (mult),
    .is_one    (is_one),
    .zero_term (!loaded),
    .coeff     (coeff),
    .bias      (bias),
    .feature   (feature_sel),
    .acc_neg   (acc_neg)
  );

  assign in_ready        = !loaded;
  assign child_direction = acc_neg ? DirLeft : DirRight;
  assign next            = next_q;
  assign class_valid     = class_valid_q;
  assign class_level     = class_level_q;
  assign class_path      = class_path_q;
  assign sample_missing  = sample_missing_q;
  assign cmd_overrun     = cmd_overrun_q;

endmodule

// File: doc/tree_node_datapath.md
# tree_node_datapath

Arithmetic responder for the decision-tree controller. It holds one feature sample and evaluates the hyperplane at each tree node, executing the controller's `load_bias`/`add`/`mult`/`is_one` command stream: accumulator = bias + Σ wₖ·xₖ. It returns the branch bit (`child_direction`) and a `next` strobe. When the controller signals a finished walk, it captures the leaf (`level`, `path`) as the classification result and releases the sample buffer.

## Interface
Parameters:
- `FEATURES`, 3: features per sample; add cycles per node.
- `COEFF_BIT_DEPTH`, 4: signed two's-complement coefficient width.
- `BIAS_BIT_DEPTH`, 10: signed bias width.
- `FEATURE_BIT_DEPTH`, 10: signed feature width.
- `ACC_BIT_DEPTH`, 18: signed accumulator width.

Ports:
- `clk`, in, 1: single clock; all state updates on rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `in_valid`, in, 1: a feature sample is offered.
- `in_ready`, out, 1: the buffer is empty and can accept a sample.
- `features`, in, FEATURES*FEATURE_BIT_DEPTH: feature k occupies bits [k*FBD +: FBD].
- `load_bias`, in, 1: first add cycle of a node.
- `add`, in, 1: accumulate the current term.
- `mult`, in, 1: the term is coeff × feature.
- `is_one`, in, 1: the term is the feature itself (unit weight).
- `coeff`, in, COEFF_BIT_DEPTH: signed coefficient.
- `bias`, in, BIAS_BIT_DEPTH: signed node bias.
- `out_valid`, in, 1: controller pulse; tree walk finished.
- `level`, in, clog2(FEATURES): final depth.
- `path`, in, clog2(FEATURES): branch bits.
- `child_direction`, out, 1: 1 when the accumulator is ≥ 0.
- `next`, out, 1: one-cycle pulse; the node decision is ready.
- `class_valid`, out, 1: one-cycle pulse with the result.
- `class_level`, out, clog2(FEATURES): captured `level`.
- `class_path`, out, clog2(FEATURES): captured `path`.
- `sample_missing`, out, 1: sticky error flag.
- `cmd_overrun`, out, 1: sticky error flag.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - LOADED: sample held, `in_ready`=0.
- Transitions:
  - IDLE→LOADED on `in_valid`; the sample is copied into the buffer.
  - LOADED→IDLE on `out_valid`.
  - While LOADED, `in_valid` is ignored.
- Feature index `fidx`:
  - `load_bias&add`: term uses `fidx`=0; after the cycle, `fidx`=1.
  - `add` alone: uses the current `fidx`, then increments it.
- Term for feature x = `features[fidx]`:
  - `is_one` → x.
  - else `mult` → coeff·x, full COEFF+FEATURE signed product.
  - else → 0.
- Accumulator update on an add cycle:
  - `load_bias` → acc ← sext(bias) + term.
  - otherwise → acc ← acc + term.
- All sums are sign-extended to ACC_BIT_DEPTH. Overflow wraps (two's complement); no saturation.
- `child_direction` = ~acc[MSB], combinational from the registered acc. It is stable from the cycle after the last add until the next `load_bias` cycle.
- `next`: registered. It is 1 in the cycle after the add cycle in which the pre-increment `fidx` = FEATURES-1; otherwise 0.
- `out_valid`:
  - Registers `level`/`path` into `class_level`/`class_path`.
  - Pulses `class_valid` the next cycle.
  - Returns to IDLE.
- `out_valid` in IDLE: ignored; no `class_valid`.
- `add` while IDLE: term is forced to 0, `sample_missing`←1.
- `add` with `fidx`=FEATURES and no `load_bias`: term 0, acc held, `cmd_overrun`←1.
- `add`=0: acc, `fidx` and `next` generation are unaffected by `mult`/`is_one`.
- `in_valid` and `out_valid` in the same cycle while LOADED: the release wins; the new sample is accepted in the following cycle (`in_ready` is 1 then).

## Timing
- Reset values:
  - acc=0, `fidx`=0, state=IDLE.
  - `in_ready`=1 (combinational from state), `child_direction`=1.
  - `next`=0, `class_valid`=0, `class_level`=0, `class_path`=0.
  - `sample_missing`=0, `cmd_overrun`=0.
- Reset mid-node clears acc and `fidx`. The next node evaluation must start with `load_bias`.
- Latency:
  - Last add edge → `child_direction` valid the same cycle that `next`=1 (the controller's DECIDE cycle).
  - `out_valid` → `class_valid` one cycle later.
- Sample acceptance: `in_valid` sampled at the edge with `in_ready`=1 → LOADED one cycle later.
- There is no combinational path from the command inputs to any output.

## Structure
- Shared package `tree_pkg`:
  - The width parameters and their derived widths (product width, clog2(FEATURES)).
  - The `child_direction` encoding constants (LEFT=0 on negative).
  - The datapath state encoding.
- Natural sub-module `tree_mac`:
  - Signed term select (one/mult/zero) plus the accumulator register with bias load.
  - Parameterised by the widths.
- The top level keeps the sample buffer, `fidx`, state, result capture and error flags.

## Test plan
- FEATURES=3, sample x=(2,-3,4); node: bias=5, `is_one` on k=0, coeff 2 at k=1, coeff -1 at k=2 → acc=5+2-6-4=-3, `child_direction`=0, `next` pulse one cycle after the third add.
- Same sample, bias=20 → acc=12, `child_direction`=1; acc=0 case (bias=8) → `child_direction`=1.
- Accumulator wrap: ACC_BIT_DEPTH=8, bias=+120, coeff 7 × x=7 → acc wraps to -87, `child_direction`=0, no error flags.
- Command stream with no sample loaded → acc=sext(bias), `sample_missing`=1 and held until reset; a 4th `add` without `load_bias` → `cmd_overrun`=1, acc unchanged.
- `out_valid` with `level`=2, `path`=1 → `class_valid` pulse next cycle with the same values, `in_ready`=1; simultaneous `in_valid` ignored that cycle, accepted on the next.
- Assert `reset` during the second add of a node → all outputs at reset values asynchronously; after release, a fresh `load_bias` node evaluates correctly.
